// File: rtl/chance_manager_pkg.sv
// Shared constants and state encoding for the chance manager and its grace timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chance_manager_pkg;

    localparam int INIT_CHANCES     = 3;
    localparam int MAX_CHANCES      = 5;
    localparam int CHANCE_W         = 3;
    localparam int INVINCIBLE_TICKS = 200;
    localparam int TIMER_W          = 8;

    typedef enum logic [2:0] {
        CM_IDLE    = 3'd0,
        CM_ARMING  = 3'd1,
        CM_PLAYING = 3'd2,
        CM_GRACE   = 3'd3,
        CM_DONE    = 3'd4
    } cm_state_t;

endpackage

// File: rtl/chance_manager_grace.sv
// Loadable down-counter timing the post-hit invincibility window.
// Latency: LOAD takes effect next cycle; DONE is combinational from the count.
// Backpressure: none; counts freely and parks at zero.
module grace_timer #(
    parameter int                 TIMER_W  = 8,
    parameter logic [TIMER_W-1:0] LOAD_VAL = '0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic LOAD,
    output logic DONE
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= '0;
        end else if (LOAD) begin
            count_q <= LOAD_VAL;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign DONE = (count_q == '0) && !LOAD;

endmodule

// File: rtl/chance_manager.sv
// Game-flow sequencer: start pulse, hurt/recover pulses, chance count, grace window, game over.
// Latency: every output is registered, 1 cycle after the sampled input.
// Backpressure: none; input pulses outside PLAYING/GRACE are dropped.
module chance_manager
    import chance_manager_pkg::*;
#(
    parameter int INIT_CHANCES_P     = INIT_CHANCES,
    parameter int MAX_CHANCES_P      = MAX_CHANCES,
    parameter int CHANCE_W_P         = CHANCE_W,
    parameter int INVINCIBLE_TICKS_P = INVINCIBLE_TICKS,
    parameter int TIMER_W_P          = TIMER_W
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  KEY_START,
    input  logic                  DROP_READY,
    input  logic                  COLLIDE,
    input  logic                  BONUS,
    output logic                  START,
    output logic                  HURT,
    output logic                  RECOVER,
    output logic                  INVINCIBLE,
    output logic                  OVER,
    output logic [CHANCE_W_P-1:0] CHANCES
);

    localparam logic [CHANCE_W_P-1:0] INIT_C = CHANCE_W_P'(INIT_CHANCES_P);
    localparam logic [CHANCE_W_P-1:0] MAX_C  = CHANCE_W_P'(MAX_CHANCES_P);
    localparam logic [CHANCE_W_P-1:0] ONE_C  = CHANCE_W_P'(1);
    localparam logic [TIMER_W_P-1:0]  GRACE_LOAD = TIMER_W_P'(INVINCIBLE_TICKS_P - 1);

    cm_state_t             state_q, state_d;
    logic                  start_q, start_d;
    logic                  hurt_q, hurt_d;
    logic                  recover_q, recover_d;
    logic                  inv_q, inv_d;
    logic                  over_q, over_d;
    logic [CHANCE_W_P-1:0] chances_q, chances_d;
    logic                  key_q;
    logic                  key_rise;
    logic                  bonus_ok;
    logic                  timer_load;
    logic                  timer_done;

    grace_timer #(
        .TIMER_W  (TIMER_W_P),
        .LOAD_VAL (GRACE_LOAD)
    ) u_grace_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .LOAD  (timer_load),
        .DONE  (timer_done)
    );

    // Sampling the key during reset too means a key held through reset release is not an edge.
    always_ff @(posedge CLK) begin
        key_q <= KEY_START;
    end

    assign key_rise = KEY_START && !key_q;
    assign bonus_ok = BONUS && (chances_q < MAX_C);

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        hurt_d     = 1'b0;
        recover_d  = 1'b0;
        inv_d      = inv_q;
        over_d     = over_q;
        chances_d  = chances_q;
        timer_load = 1'b0;
        case (state_q)
            CM_IDLE: begin
                if (key_rise) begin
                    start_d   = 1'b1;
                    chances_d = INIT_C;
                    state_d   = CM_ARMING;
                end
            end
            CM_ARMING: begin
                if (DROP_READY) state_d = CM_PLAYING;
            end
            CM_PLAYING: begin
                if (COLLIDE) begin
                    hurt_d = 1'b1;
                    if (chances_q > ONE_C) begin
                        chances_d  = chances_q - 1'b1;
                        inv_d      = 1'b1;
                        timer_load = 1'b1;
                        state_d    = CM_GRACE;
                    end else begin
                        chances_d = '0;
                        over_d    = 1'b1;
                        state_d   = CM_DONE;
                    end
                end else if (bonus_ok) begin
                    chances_d = chances_q + 1'b1;
                    recover_d = 1'b1;
                end
            end
            CM_GRACE: begin
                if (bonus_ok) begin
                    chances_d = chances_q + 1'b1;
                    recover_d = 1'b1;
                end
                if (timer_done) begin
                    inv_d   = 1'b0;
                    state_d = CM_PLAYING;
                end
            end
            CM_DONE: begin
                over_d = 1'b1;
            end
            default: begin
                state_d   = CM_IDLE;
                inv_d     = 1'b0;
                over_d    = 1'b0;
                chances_d = INIT_C;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= CM_IDLE;
            start_q   <= 1'b0;
            hurt_q    <= 1'b0;
            recover_q <= 1'b0;
            inv_q     <= 1'b0;
            over_q    <= 1'b0;
            chances_q <= INIT_C;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            hurt_q    <= hurt_d;
            recover_q <= recover_d;
            inv_q     <= inv_d;
            over_q    <= over_d;
            chances_q <= chances_d;
        end
    end

    assign START      = start_q;
    assign HURT       = hurt_q;
    assign RECOVER    = recover_q;
    assign INVINCIBLE = inv_q;
    assign OVER       = over_q;
    assign CHANCES    = chances_q;

endmodule

// File: tb/tb_chance_manager.sv
// Scoreboard bench for chance_manager: scripted game scenarios then random play,
// each cycle's expected outputs come from a phase/count reference model.
module tb_chance_manager;

    localparam int INIT_C = 3;
    localparam int MAX_C  = 5;
    localparam int TICKS  = 200;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_PLAY = 2;
    localparam int P_OVER = 3;

    typedef struct packed {
        logic       start;
        logic       hurt;
        logic       recover;
        logic       inv;
        logic       over;
        logic [2:0] chances;
    } obs_t;

    logic       CLK;
    logic       RESET;
    logic       KEY_START;
    logic       DROP_READY;
    logic       COLLIDE;
    logic       BONUS;
    logic       START;
    logic       HURT;
    logic       RECOVER;
    logic       INVINCIBLE;
    logic       OVER;
    logic [2:0] CHANCES;

    chance_manager dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .KEY_START  (KEY_START),
        .DROP_READY (DROP_READY),
        .COLLIDE    (COLLIDE),
        .BONUS      (BONUS),
        .START      (START),
        .HURT       (HURT),
        .RECOVER    (RECOVER),
        .INVINCIBLE (INVINCIBLE),
        .OVER       (OVER),
        .CHANCES    (CHANCES)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    // Reference model: game phase, remaining shielded cycles, chance count.
    int   phase      = P_IDLE;
    int   m_chances  = INIT_C;
    int   grace_left = 0;
    bit   key_prev   = 1'b0;
    bit   key_lvl    = 1'b0;
    bit   drop_lvl   = 1'b0;

    task automatic model_step(input bit rst, input bit key, input bit drop,
                              input bit col, input bit bon, output obs_t e);
        bit rise;
        bit shielded;
        e = '0;
        if (rst) begin
            phase      = P_IDLE;
            m_chances  = INIT_C;
            grace_left = 0;
            key_prev   = key;
        end else begin
            rise     = key && !key_prev;
            key_prev = key;
            case (phase)
                P_IDLE: if (rise) begin
                    e.start   = 1'b1;
                    m_chances = INIT_C;
                    phase     = P_WAIT;
                end
                P_WAIT: if (drop) phase = P_PLAY;
                P_PLAY: begin
                    shielded = (grace_left > 0);
                    if (grace_left > 0) grace_left--;
                    if (col && !shielded) begin
                        e.hurt = 1'b1;
                        m_chances = (m_chances > 0) ? m_chances - 1 : 0;
                        if (m_chances == 0) phase = P_OVER;
                        else grace_left = TICKS;
                    end else if (bon && m_chances < MAX_C) begin
                        e.recover = 1'b1;
                        m_chances++;
                    end
                end
                default: ;
            endcase
        end
        e.inv     = (grace_left > 0);
        e.over    = (phase == P_OVER);
        e.chances = 3'(m_chances);
    endtask

    task automatic step(input bit rst, input bit key, input bit drop,
                        input bit col, input bit bon);
        obs_t e;
        RESET      = rst;
        KEY_START  = key;
        DROP_READY = drop;
        COLLIDE    = col;
        BONUS      = bon;
        @(posedge CLK);
        model_step(rst, key, drop, col, bon, e);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic tick(input bit col, input bit bon);
        step(1'b0, key_lvl, drop_lvl, col, bon);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, key_lvl, drop_lvl, 1'b0, 1'b0);
    endtask

    task automatic start_game();
        key_lvl = 1'b0; tick(1'b0, 1'b0);
        key_lvl = 1'b1; tick(1'b0, 1'b0);
        idle(3);
        key_lvl = 1'b0; tick(1'b0, 1'b0);
        drop_lvl = 1'b1; tick(1'b0, 1'b0);
        drop_lvl = 1'b0; idle(2);
    endtask

    // Monitor: one expected observation per clock, compared away from the active edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {START, HURT, RECOVER, INVINCIBLE, OVER, CHANCES};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got start=%b hurt=%b rec=%b inv=%b over=%b chances=%0d want start=%b hurt=%b rec=%b inv=%b over=%b chances=%0d",
                             $time, a.start, a.hurt, a.recover, a.inv, a.over, a.chances,
                             e.start, e.hurt, e.recover, e.inv, e.over, e.chances);
                end
            end
        end
    end

    initial begin
        RESET = 1'b1; KEY_START = 1'b0; DROP_READY = 1'b0; COLLIDE = 1'b0; BONUS = 1'b0;

        // Key held through reset release must not start a game.
        key_lvl = 1'b1;
        do_reset(3);
        idle(4);

        // Start, collisions while arming, then first hit.
        key_lvl = 1'b0; tick(1'b0, 1'b0);
        key_lvl = 1'b1; tick(1'b0, 1'b0);
        idle(5);
        key_lvl = 1'b0;
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b1);
        drop_lvl = 1'b1; tick(1'b0, 1'b0);
        drop_lvl = 1'b0; idle(2);
        tick(1'b1, 1'b0);

        // Collisions inside the grace window, then one after it.
        idle(9);   tick(1'b1, 1'b0);
        idle(139); tick(1'b1, 1'b0);
        idle(60);  tick(1'b1, 1'b0);

        // Bonuses up to the ceiling, then simultaneous collide+bonus.
        tick(1'b0, 1'b1); idle(1); tick(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin tick(1'b0, 1'b1); idle(1); end
        idle(205);
        tick(1'b1, 1'b1);

        // Drain chances to zero, then a key edge while over.
        for (int i = 0; i < 4; i++) begin idle(205); tick(1'b1, 1'b0); end
        idle(3);
        key_lvl = 1'b1; tick(1'b0, 1'b0); idle(2);
        key_lvl = 1'b0; tick(1'b1, 1'b1); idle(2);

        // Reset in the middle of a grace window.
        do_reset(1);
        start_game();
        tick(1'b1, 1'b0);
        idle(142);
        do_reset(1);
        idle(4);

        // Random play with occasional resets.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 29) == 0) key_lvl = !key_lvl;
            drop_lvl = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 599) == 0)
                step(1'b1, key_lvl, drop_lvl, 1'b0, 1'b0);
            else
                tick($urandom_range(0, 8) == 0, $urandom_range(0, 6) == 0);
        end

        @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
